// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the divider requester.
// Holds the sequencer state encoding and the default WIDTH/TIMEOUT values
// used by the sequencer and its command/response interface.
package div_sequencer_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_TIMEOUT = 80;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/div_sequencer_if.sv
// Command/response port of the divider requester.
// cmd_*: valid/ready divide command (sel picks operand pair 1 or 2).
// rsp_*: one-cycle rsp_valid pulse with registered quotient and flags.
// master: the control logic issuing commands; slave: the sequencer.
interface div_sequencer_if
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_sel;
  logic [WIDTH-1:0] cmd_dividend;
  logic [WIDTH-1:0] cmd_divisor;

  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_quot;
  logic             rsp_dbz;
  logic             rsp_timeout;

  modport master (
    output cmd_valid, cmd_sel, cmd_dividend, cmd_divisor,
    input  cmd_ready, rsp_valid, rsp_quot, rsp_dbz, rsp_timeout
  );

  modport slave (
    input  cmd_valid, cmd_sel, cmd_dividend, cmd_divisor,
    output cmd_ready, rsp_valid, rsp_quot, rsp_dbz, rsp_timeout
  );

endinterface

// File: rtl/div_sequencer.sv
// Requester side of the divider handshake. Serialises divide commands to a
// single divider: loads the chosen operand pair, drives en/Select, waits for
// Ready with Busy low, and returns the captured quotient on the response port.
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   cmd_if (slave)  command valid/ready + response pulse/fields
//   div_en          divider enable (high in ARM and RUN only)
//   div_select      divider Select (1: pair 1, 0: pair 2)
//   div_dvd1/2      Dividend1/Dividend2
//   div_dvs1/2      Divisor1/Divisor2
//   div_res         divider result
//   div_busy        divider Busy
//   div_ready       divider Ready
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  div_sequencer_if.slave   cmd_if,
  output logic             div_en,
  output logic             div_select,
  output logic [WIDTH-1:0] div_dvd1,
  output logic [WIDTH-1:0] div_dvs1,
  output logic [WIDTH-1:0] div_dvd2,
  output logic [WIDTH-1:0] div_dvs2,
  input  logic [WIDTH-1:0] div_res,
  input  logic             div_busy,
  input  logic             div_ready
);

  localparam int            TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  seq_state_e       state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             sel_q, sel_d;
  logic [WIDTH-1:0] dvd1_q, dvd1_d, dvs1_q, dvs1_d;
  logic [WIDTH-1:0] dvd2_q, dvd2_d, dvs2_q, dvs2_d;
  logic             dbz_pend_q, dbz_pend_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic             dbz_q, dbz_d;
  logic             tout_q, tout_d;
  logic             cmd_fire;

  // cmd_ready is masked by rst so nothing is accepted in the reset cycle.
  assign cmd_if.cmd_ready   = (state_q == S_IDLE) && !rst;
  assign cmd_fire           = cmd_if.cmd_valid && cmd_if.cmd_ready;

  assign cmd_if.rsp_valid   = (state_q == S_DONE);
  assign cmd_if.rsp_quot    = quot_q;
  assign cmd_if.rsp_dbz     = dbz_q;
  assign cmd_if.rsp_timeout = tout_q;

  // en is dropped in DONE so the divider cannot restart on stale operands.
  assign div_en     = (state_q == S_ARM) || (state_q == S_RUN);
  assign div_select = sel_q;
  assign div_dvd1   = dvd1_q;
  assign div_dvs1   = dvs1_q;
  assign div_dvd2   = dvd2_q;
  assign div_dvs2   = dvs2_q;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    sel_d      = sel_q;
    dvd1_d     = dvd1_q;
    dvs1_d     = dvs1_q;
    dvd2_d     = dvd2_q;
    dvs2_d     = dvs2_q;
    dbz_pend_d = dbz_pend_q;
    quot_d     = quot_q;
    dbz_d      = dbz_q;
    tout_d     = tout_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          if (cmd_if.cmd_sel) begin
            dvd1_d = cmd_if.cmd_dividend;
            dvs1_d = cmd_if.cmd_divisor;
          end else begin
            dvd2_d = cmd_if.cmd_dividend;
            dvs2_d = cmd_if.cmd_divisor;
          end
          sel_d      = cmd_if.cmd_sel;
          dbz_pend_d = (cmd_if.cmd_divisor == '0);
          timer_d    = '0;
          state_d    = S_ARM;
        end
      end

      // Ready may still be high from the previous operation; only Busy
      // rising is meaningful here.
      S_ARM: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == T_LAST) begin
          quot_d  = '0;
          dbz_d   = dbz_pend_q;
          tout_d  = 1'b1;
          state_d = S_DONE;
        end else if (div_busy) begin
          state_d = S_RUN;
        end
      end

      // A completion seen on the last timer cycle still wins over timeout.
      S_RUN: begin
        timer_d = timer_q + 1'b1;
        if (div_ready && !div_busy) begin
          quot_d  = dbz_pend_q ? '0 : div_res;
          dbz_d   = dbz_pend_q;
          tout_d  = 1'b0;
          state_d = S_DONE;
        end else if (timer_q == T_LAST) begin
          quot_d  = '0;
          dbz_d   = dbz_pend_q;
          tout_d  = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      sel_q      <= 1'b0;
      dvd1_q     <= '0;
      dvs1_q     <= '0;
      dvd2_q     <= '0;
      dvs2_q     <= '0;
      dbz_pend_q <= 1'b0;
      quot_q     <= '0;
      dbz_q      <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      sel_q      <= sel_d;
      dvd1_q     <= dvd1_d;
      dvs1_q     <= dvs1_d;
      dvd2_q     <= dvd2_d;
      dvs2_q     <= dvs2_d;
      dbz_pend_q <= dbz_pend_d;
      quot_q     <= quot_d;
      dbz_q      <= dbz_d;
      tout_q     <= tout_d;
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: directed cases plus random commands against a
// behavioural divider (with a stall mode) and an arithmetic reference.
module tb_div_sequencer;
  import div_sequencer_pkg::*;

  localparam int W  = DEF_WIDTH;
  localparam int TO = DEF_TIMEOUT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_sequencer_if #(.WIDTH(W)) cmd_if ();

  logic         div_en, div_select;
  logic [W-1:0] dvd1, dvs1, dvd2, dvs2;
  logic [W-1:0] div_res   = '0;
  logic         div_busy  = 1'b0;
  logic         div_ready = 1'b0;

  div_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_if     (cmd_if),
    .div_en     (div_en),
    .div_select (div_select),
    .div_dvd1   (dvd1),
    .div_dvs1   (dvs1),
    .div_dvd2   (dvd2),
    .div_dvs2   (dvs2),
    .div_res    (div_res),
    .div_busy   (div_busy),
    .div_ready  (div_ready)
  );

  // Divider model: one enabled cycle clears the post-completion hold, Busy
  // rises the next enabled cycle, result after 4*W busy cycles. Divide by
  // zero pulses Ready one cycle after Busy. Dropping en aborts to hold.
  typedef enum {M_IDLE, M_BUSY, M_HOLD} mst_e;
  mst_e         m_st  = M_IDLE;
  int           m_cnt = 0;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic         stall = 1'b0;

  always @(posedge clk) begin
    case (m_st)
      M_IDLE: if (div_en) begin
        m_a       <= div_select ? dvd1 : dvd2;
        m_b       <= div_select ? dvs1 : dvs2;
        m_cnt     <= 0;
        div_busy  <= 1'b1;
        div_ready <= 1'b0;
        m_st      <= M_BUSY;
      end
      M_BUSY: begin
        if (!div_en) begin
          div_busy <= 1'b0;
          m_st     <= M_HOLD;
        end else if (stall) begin
          m_cnt <= m_cnt;
        end else if (m_b == '0) begin
          div_busy  <= 1'b0;
          div_ready <= 1'b1;
          div_res   <= '1;
          m_st      <= M_HOLD;
        end else if (m_cnt == 4*W-1) begin
          div_busy  <= 1'b0;
          div_ready <= 1'b1;
          div_res   <= m_a / m_b;
          m_st      <= M_HOLD;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
      default: if (div_en) begin
        div_ready <= 1'b0;
        m_st      <= M_IDLE;
      end
    endcase
  end

  // Monitors: response pulse count, and select/operands stable while en.
  int             pulses = 0;
  int             viol   = 0;
  logic           p_en   = 1'b0;
  logic           p_sel  = 1'b0;
  logic [4*W-1:0] p_ops  = '0;

  always @(posedge clk) begin
    if (cmd_if.rsp_valid) pulses <= pulses + 1;
    if (div_en && p_en && ({div_select, dvd1, dvs1, dvd2, dvs2} != {p_sel, p_ops}))
      viol <= viol + 1;
    p_en  <= div_en;
    p_sel <= div_select;
    p_ops <= {dvd1, dvs1, dvd2, dvs2};
  end

  int           ncmp = 0;
  int           nfail = 0;
  int           p_start = 0;
  logic [W-1:0] s1a = '0, s1b = '0, s2a = '0, s2b = '0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_quot(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == '0) ? '0 : a / b;
  endfunction

  // Presents a command, waits for acceptance, returns on the first ARM cycle.
  task automatic send(input logic sel, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    p_start              = pulses;
    cmd_if.cmd_valid     = 1'b1;
    cmd_if.cmd_sel       = sel;
    cmd_if.cmd_dividend  = a;
    cmd_if.cmd_divisor   = b;
    while (!cmd_if.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_if.cmd_ready) chk("hs_timeout", 64'd0, 64'd1);
    if (sel) begin s1a = a; s1b = b; end
    else     begin s2a = a; s2b = b; end
    @(negedge clk);
  endtask

  task automatic wait_rsp(input string tag, input logic [W-1:0] eq, input logic edbz,
                          input logic eto, output int lat);
    int rdy = 0;
    lat = 0;
    while (!cmd_if.rsp_valid && lat < TO + 20) begin
      if (cmd_if.cmd_ready) rdy++;
      lat++;
      @(negedge clk);
    end
    chk({tag, "_seen"}, 64'(cmd_if.rsp_valid), 64'd1);
    chk({tag, "_quot"}, 64'(cmd_if.rsp_quot), 64'(eq));
    chk({tag, "_flags"}, {62'd0, cmd_if.rsp_dbz, cmd_if.rsp_timeout}, {62'd0, edbz, eto});
    chk({tag, "_rdy_low"}, 64'(rdy), 64'd0);
    chk({tag, "_pairs"}, {dvd1, dvs1, dvd2, dvs2}, {s1a, s1b, s2a, s2b});
    chk({tag, "_en_done"}, 64'(div_en), 64'd0);
    @(negedge clk);
    chk({tag, "_after"}, {61'd0, cmd_if.rsp_valid, div_en, 1'b0}, 64'd0);
    chk({tag, "_hold"}, 64'(cmd_if.rsp_quot), 64'(eq));
    chk({tag, "_pulses"}, 64'(pulses - p_start), 64'd1);
  endtask

  task automatic op(input string tag, input logic sel, input logic [W-1:0] a,
                    input logic [W-1:0] b, output int lat);
    send(sel, a, b);
    cmd_if.cmd_valid = 1'b0;
    wait_rsp(tag, ref_quot(a, b), (b == '0), 1'b0, lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    logic [W-1:0] ra, rb;
    logic         rs;
    cmd_if.cmd_valid    = 1'b0;
    cmd_if.cmd_sel      = 1'b0;
    cmd_if.cmd_dividend = '0;
    cmd_if.cmd_divisor  = '0;

    // Reset state
    @(negedge clk);
    chk("rst_ready", 64'(cmd_if.cmd_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 64'(cmd_if.cmd_ready), 64'd1);
    chk("rst_ctl", {59'd0, cmd_if.rsp_valid, cmd_if.rsp_dbz, cmd_if.rsp_timeout, div_en, div_select}, 64'd0);
    chk("rst_quot", 64'(cmd_if.rsp_quot), 64'd0);
    chk("rst_pairs", {dvd1, dvs1, dvd2, dvs2}, 64'd0);

    // 1: pair 1, pair 2 untouched
    op("t1", 1'b1, 16'd100, 16'd7, lat);

    // 2: pair 2, select low throughout
    op("t2", 1'b0, 16'hFFFF, 16'h0010, lat);
    chk("t2_stable", 64'(viol), 64'd0);

    // 3: divide by zero, well before timeout
    op("t3", 1'b1, 16'd1234, 16'd0, lat);
    chk("t3_fast", 64'(lat < TO/2), 64'd1);

    // 4: back-to-back with cmd_valid held
    send(1'b1, 16'd50, 16'd5);
    cmd_if.cmd_dividend = 16'd9;
    cmd_if.cmd_divisor  = 16'd3;
    wait_rsp("t4a", 16'd10, 1'b0, 1'b0, lat);
    send(1'b1, 16'd9, 16'd3);
    cmd_if.cmd_valid = 1'b0;
    wait_rsp("t4b", 16'd3, 1'b0, 1'b0, lat);

    // 5: stalled divider -> timeout exactly TO cycles after ARM entry
    stall = 1'b1;
    send(1'b0, 16'd77, 16'd7);
    cmd_if.cmd_valid = 1'b0;
    wait_rsp("t5", 16'd0, 1'b0, 1'b1, lat);
    chk("t5_lat", 64'(lat), 64'(TO));
    stall = 1'b0;

    // 6: reset in the middle of RUN
    send(1'b1, 16'd200, 16'd3);
    cmd_if.cmd_valid = 1'b0;
    n = 0;
    while (!div_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_busy", 64'(div_busy), 64'd1);
    repeat (21) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_ctl", {58'd0, cmd_if.cmd_ready, cmd_if.rsp_valid, cmd_if.rsp_dbz,
                   cmd_if.rsp_timeout, div_en, div_select}, 64'd0);
    chk("t6_quot", 64'(cmd_if.rsp_quot), 64'd0);
    chk("t6_pairs", {dvd1, dvs1, dvd2, dvs2}, 64'd0);
    rst = 1'b0;
    s1a = '0; s1b = '0; s2a = '0; s2b = '0;
    @(negedge clk);
    op("t6b", 1'b1, 16'd81, 16'd9, lat);

    // Random commands
    for (int i = 0; i < 16; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = W'($urandom);
      rb = W'($urandom) >> $urandom_range(0, 15);
      if ($urandom_range(0, 5) == 0) rb = '0;
      op("rnd", rs, ra, rb, lat);
    end

    chk("sel_stable", 64'(viol), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
